// File: rtl/alu_op_sequencer.sv
// Initiator for the combinational ALU add/subtract unit: accepts one request, drives the
// adder/subtractor for exactly one cycle, and holds the registered result until it is consumed.
module alu_op_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_fn,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [5:0]       alu_fn,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_z,
    output logic             out_v,
    output logic             out_n,
    output logic             out_err
);

    localparam logic [5:0] FnAdd   = 6'b000000;
    localparam logic [5:0] FnSub   = 6'b000001;
    localparam logic [5:0] FnCmpEq = 6'b110011;
    localparam logic [5:0] FnCmpLt = 6'b110101;
    localparam logic [5:0] FnCmpLe = 6'b110111;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

    state_e     state_q;
    logic [5:0] fn_q;

    // Compares are subtractions; unsupported codes still drive the unit with ADD.
    function automatic logic [5:0] alu_fn_of(input logic [5:0] fn);
        case (fn)
            FnSub, FnCmpEq, FnCmpLt, FnCmpLe: alu_fn_of = FnSub;
            default:                          alu_fn_of = FnAdd;
        endcase
    endfunction

    logic [WIDTH-1:0] result_d;
    logic             err_d;
    logic             lt;

    assign lt = alu_n ^ alu_v;

    always_comb begin
        result_d = '0;
        err_d    = 1'b0;
        case (fn_q)
            FnAdd, FnSub: result_d = alu_s;
            FnCmpEq:      result_d = {{(WIDTH-1){1'b0}}, alu_z};
            FnCmpLt:      result_d = {{(WIDTH-1){1'b0}}, lt};
            FnCmpLe:      result_d = {{(WIDTH-1){1'b0}}, alu_z | lt};
            default:      err_d    = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            fn_q       <= '0;
            in_ready   <= 1'b1;
            alu_fn     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_z      <= 1'b0;
            out_v      <= 1'b0;
            out_n      <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        fn_q     <= in_fn;
                        alu_fn   <= alu_fn_of(in_fn);
                        alu_a    <= in_a;
                        alu_b    <= in_b;
                        in_ready <= 1'b0;
                        state_q  <= StExec;
                    end
                end
                StExec: begin
                    alu_fn     <= '0;
                    alu_a      <= '0;
                    alu_b      <= '0;
                    out_result <= result_d;
                    out_err    <= err_d;
                    // Flags of an unsupported request are meaningless, so report them as 0.
                    out_z      <= alu_z & ~err_d;
                    out_v      <= alu_v & ~err_d;
                    out_n      <= alu_n & ~err_d;
                    out_valid  <= 1'b1;
                    state_q    <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural adder/subtractor model.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_fn;
    logic [31:0] in_a, in_b;
    logic [5:0]  alu_fn;
    logic [31:0] alu_a, alu_b, alu_s;
    logic        alu_z, alu_v, alu_n;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_z, out_v, out_n, out_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Adder/subtractor model
    assign alu_s = alu_fn[0] ? (alu_a - alu_b) : (alu_a + alu_b);
    assign alu_z = (alu_s == 32'd0);
    assign alu_n = alu_s[31];
    assign alu_v = alu_fn[0] ? ((alu_a[31] != alu_b[31]) && (alu_s[31] != alu_a[31]))
                             : ((alu_a[31] == alu_b[31]) && (alu_s[31] != alu_a[31]));

    alu_op_sequencer #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fn     (in_fn),
        .in_a      (in_a),
        .in_b      (in_b),
        .alu_fn    (alu_fn),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_z     (alu_z),
        .alu_v     (alu_v),
        .alu_n     (alu_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_z     (out_z),
        .out_v     (out_v),
        .out_n     (out_n),
        .out_err   (out_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; leaves the bench at a negedge back in IDLE.
    task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] exp_fn,
                          input logic [31:0] exp_res, input logic exp_z, input logic exp_v,
                          input logic exp_n, input logic exp_err);
        out_ready = 1'b1;
        in_fn = fn; in_a = a; in_b = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".exec_alu_fn"}, {26'd0, alu_fn}, {26'd0, exp_fn});
        chk({tag, ".exec_alu_a"}, alu_a, a);
        chk({tag, ".exec_alu_b"}, alu_b, b);
        chk({tag, ".exec_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, ".exec_out_valid"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, ".done_out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".done_alu_fn"}, {26'd0, alu_fn}, 32'd0);
        chk({tag, ".done_alu_a"}, alu_a, 32'd0);
        chk({tag, ".result"}, out_result, exp_res);
        chk({tag, ".flags_zvn_err"}, {28'd0, out_z, out_v, out_n, out_err},
            {28'd0, exp_z, exp_v, exp_n, exp_err});
        chk({tag, ".done_in_ready"}, {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk({tag, ".idle_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".idle_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ".idle_result_hold"}, out_result, exp_res);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_fn = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.out_result", out_result, 32'd0);
        chk("rst.alu_fn", {26'd0, alu_fn}, 32'd0);
        chk("rst.flags_err", {28'd0, out_z, out_v, out_n, out_err}, 32'd0);

        // Reset while EXEC holds a request
        out_ready = 1'b1;
        in_fn = 6'b000000; in_a = 32'd7; in_b = 32'd9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort.exec_alu_a", alu_a, 32'd7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort.in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort.out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort.alu_a", alu_a, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort.no_result", {31'd0, out_valid}, 32'd0);
        end

        run_op("add_ovf", 6'b000000, 32'h7FFFFFFF, 32'h00000001, 6'b000000,
               32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0);
        run_op("sub_eq", 6'b000001, 32'd5, 32'd5, 6'b000001,
               32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("cmplt", 6'b110101, 32'h80000000, 32'd1, 6'b000001,
               32'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("cmple", 6'b110111, 32'd3, 32'd3, 6'b000001,
               32'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("cmpeq", 6'b110011, 32'd3, 32'd4, 6'b000001,
               32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("unsup", 6'b101010, 32'd10, 32'd20, 6'b000000,
               32'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Stall: ADD 1+1 held with out_ready low, next request waiting
        out_ready = 1'b0;
        in_fn = 6'b000000; in_a = 32'd1; in_b = 32'd1; in_valid = 1'b1;
        @(negedge clk);
        in_fn = 6'b000001; in_a = 32'd9; in_b = 32'd4;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall.out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall.out_result", out_result, 32'd2);
            chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall.release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("stall.release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("stall.not_accepted_alu_fn", {26'd0, alu_fn}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b.exec_alu_fn", {26'd0, alu_fn}, 32'd1);
        chk("b2b.exec_alu_a", alu_a, 32'd9);
        @(negedge clk);
        chk("b2b.result", out_result, 32'd5);
        chk("b2b.out_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        chk("b2b.idle_in_ready", {31'd0, in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
